// File: rtl/paralelo_serial_8_1_pkg.sv
// Shared constants and state encoding for the transmit parallel-to-serial stage.
package paralelo_serial_8_1_pkg;

  localparam int         WIDTH_DEF   = 8;
  localparam logic [7:0] COM_SYM     = 8'hBC;  // K28.5 payload
  localparam int         COM_MIN_DEF = 4;

  typedef enum logic {
    SYNC = 1'b0,
    DATA = 1'b1
  } state_t;

endpackage

// File: rtl/paralelo_serial_8_1.sv
// Parallel-to-serial stage: one byte per WIDTH clocks, MSB first, COM fills idle slots.
// Latency: byte sampled at the load edge is on data_out for the next WIDTH clocks; no backpressure.
module paralelo_serial_8_1
  import paralelo_serial_8_1_pkg::*;
#(
  parameter int               WIDTH   = WIDTH_DEF,
  parameter logic [WIDTH-1:0] COM     = WIDTH'(COM_SYM),
  parameter int               COM_MIN = COM_MIN_DEF
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             data_out,
  output logic             load,
  output logic             synced,
  output logic             dropped
);

  localparam int              BW       = $clog2(WIDTH);
  localparam int              CW       = $clog2(COM_MIN + 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0]   COM_LAST = CW'(COM_MIN - 1);

  state_t           state, state_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [CW-1:0]    com_cnt, com_cnt_nxt;
  logic             dropped_nxt;

  assign load     = (bit_cnt == LAST_BIT);
  assign data_out = shift_reg[WIDTH-1];
  assign synced   = (state == DATA);

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg << 1;
    com_cnt_nxt = com_cnt;
    dropped_nxt = 1'b0;
    if (load) begin
      case (state)
        SYNC: begin
          // preamble slots always carry COM; any offered byte is lost
          shift_nxt   = COM;
          com_cnt_nxt = com_cnt + CW'(1);
          dropped_nxt = valid_in;
          if (com_cnt == COM_LAST) state_nxt = DATA;
        end
        DATA: begin
          shift_nxt = valid_in ? data_in : COM;
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= SYNC;
      bit_cnt   <= '0;
      shift_reg <= '0;
      com_cnt   <= '0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt + BW'(1);
      shift_reg <= shift_nxt;
      com_cnt   <= com_cnt_nxt;
      dropped   <= dropped_nxt;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_8_1.sv
// Bench for paralelo_serial_8_1: randomized slots checked against a slot-level serial model.
module tb_paralelo_serial_8_1;

  localparam int         COM_MIN = 4;
  localparam logic [7:0] COM     = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out, load, synced, dropped;
  logic [3:0] obs;

  int total = 0;
  int bad   = 0;

  // model: edges since reset release, byte currently being shifted, drop flag of last boundary
  int         e;
  logic [7:0] mbyte;
  logic       mdrop;
  logic [3:0] exp_obs;

  paralelo_serial_8_1 #(.WIDTH(8), .COM(COM), .COM_MIN(COM_MIN)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in),
    .valid_in(valid_in),
    .data_out(data_out),
    .load    (load),
    .synced  (synced),
    .dropped (dropped)
  );

  always #5 clk_32f = ~clk_32f;

  assign obs = {data_out, load, synced, dropped};

  function automatic logic [3:0] model_outputs();
    logic d, l, s, r;
    d = (e >= 8) ? mbyte[7 - (e % 8)] : 1'b0;
    l = (e % 8 == 7);
    s = (e >= 8 * COM_MIN);
    r = (e >= 8 && e % 8 == 0) ? mdrop : 1'b0;
    return {d, l, s, r};
  endfunction

  // One clock: drive inputs, advance the model on the edge, leave at the falling edge.
  task automatic tick(input logic v, input logic [7:0] d);
    int k;
    valid_in = v;
    data_in  = d;
    @(posedge clk_32f);
    e++;
    if (e % 8 == 0) begin
      k = e / 8;
      if (k <= COM_MIN) begin
        mbyte = COM;
        mdrop = v;
      end else begin
        mbyte = v ? d : COM;
        mdrop = 1'b0;
      end
    end
    @(negedge clk_32f);
    exp_obs = model_outputs();
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
    e     = 0;
    mbyte = '0;
    mdrop = 1'b0;
    exp_obs = model_outputs();
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    #1;
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async got=%b want=0000", obs);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_32f);
      total++;
      if (obs !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=0000", i, obs);
      end
    end
    reset = 1'b1;
    e     = 0;
    mbyte = '0;
    mdrop = 1'b0;
    #1;
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL reset_release got=%b want=0000", obs);
    end
  endtask

  task automatic test_preamble();
    int first_sync;
    first_sync = -1;
    for (int s = 0; s < COM_MIN + 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 7) tick(1'b0, 8'($urandom));
        else        tick(1'($urandom), 8'($urandom));
        total++;
        if (obs !== exp_obs) begin
          bad++;
          $display("FAIL preamble e=%0d got=%b want=%b", e, obs, exp_obs);
        end
        if (synced === 1'b1 && first_sync < 0) first_sync = e;
      end
    end
    total++;
    if (first_sync != 8 * COM_MIN) begin
      bad++;
      $display("FAIL synced_rise edge got=%0d want=%0d", first_sync, 8 * COM_MIN);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [4];
    logic [31:0] cap;
    int          ncap;
    bytes = '{8'hEE, 8'hFF, 8'h99, 8'h00};
    cap  = '0;
    ncap = 0;
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 7 && s < 4) tick(1'b1, bytes[s]);
        else if (i == 7)     tick(1'b0, 8'($urandom));
        else                 tick(1'($urandom), 8'($urandom));
        total++;
        if (obs !== exp_obs) begin
          bad++;
          $display("FAIL back_to_back e=%0d got=%b want=%b", e, obs, exp_obs);
        end
        if ((s > 0 || i == 7) && ncap < 32) begin
          cap = {cap[30:0], data_out};
          ncap++;
        end
      end
    end
    total++;
    if (cap !== 32'hEEFF9900) begin
      bad++;
      $display("FAIL b2b_stream got=%h want=eeff9900", cap);
    end
  endtask

  task automatic test_gap();
    logic        vs [4];
    logic [7:0]  ds [4];
    logic [23:0] cap;
    int          ncap;
    vs = '{1'b1, 1'b0, 1'b1, 1'b0};
    ds = '{8'h12, 8'hA7, 8'h34, 8'h5A};
    cap  = '0;
    ncap = 0;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 7) tick(vs[s], ds[s]);
        else        tick(1'($urandom), 8'($urandom));
        total++;
        if (obs !== exp_obs) begin
          bad++;
          $display("FAIL gap e=%0d got=%b want=%b", e, obs, exp_obs);
        end
        if ((s > 0 || i == 7) && ncap < 24) begin
          cap = {cap[22:0], data_out};
          ncap++;
        end
      end
    end
    total++;
    if (cap !== 24'h12BC34) begin
      bad++;
      $display("FAIL gap_stream got=%h want=12bc34", cap);
    end
  endtask

  task automatic test_com_data_and_random();
    logic [7:0] cap;
    cap = '0;
    for (int s = 0; s < 18; s++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 7 && s == 0) tick(1'b1, COM);
        else                  tick(1'($urandom), 8'($urandom));
        total++;
        if (obs !== exp_obs) begin
          bad++;
          $display("FAIL com_random e=%0d got=%b want=%b", e, obs, exp_obs);
        end
        if ((s == 0 && i == 7) || (s == 1 && i < 7)) cap = {cap[6:0], data_out};
      end
    end
    total++;
    if (cap !== COM || synced !== 1'b1) begin
      bad++;
      $display("FAIL com_as_data got=%h/%b want=bc/1", cap, synced);
    end
  endtask

  task automatic test_drop_preamble();
    int         ndrop;
    logic [7:0] cap;
    do_reset();
    ndrop = 0;
    cap   = '0;
    for (int s = 0; s < COM_MIN + 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        tick(1'b1, 8'h55);
        total++;
        if (obs !== exp_obs) begin
          bad++;
          $display("FAIL drop e=%0d got=%b want=%b", e, obs, exp_obs);
        end
        if (dropped === 1'b1) ndrop++;
        if (e >= 8 * (COM_MIN + 1) && e < 8 * (COM_MIN + 2)) cap = {cap[6:0], data_out};
      end
    end
    total++;
    if (ndrop != COM_MIN || cap !== 8'h55) begin
      bad++;
      $display("FAIL drop_count got=%0d/%h want=%0d/55", ndrop, cap, COM_MIN);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 8'hFF);
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset got=%b want=0000", obs);
    end
    do_reset();
    for (int s = 0; s < COM_MIN + 3; s++) begin
      for (int i = 0; i < 8; i++) begin
        tick(1'($urandom), 8'($urandom));
        total++;
        if (obs !== exp_obs) begin
          bad++;
          $display("FAIL mid_reset_resync e=%0d got=%b want=%b", e, obs, exp_obs);
        end
      end
    end
  endtask

  initial begin
    e = 0;
    mbyte = '0;
    mdrop = 1'b0;
    exp_obs = '0;
    test_reset();
    test_preamble();
    test_back_to_back();
    test_gap();
    test_com_data_and_random();
    test_drop_preamble();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
